// File: rtl/nfc_pkg.sv
// Shared NAND flash controller definitions: ACG bus field widths, idle values,
// command bit positions and the command-dispatch state type.
package nfc_pkg;

  localparam int AcgCommandWidth   = 8;
  localparam int AcgOptionWidth    = 3;
  localparam int AcgNumOfDataWidth = 16;
  localparam int AcgCADataWidth    = 40;

  localparam logic [AcgCommandWidth-1:0]   AcgIdleCommand       = '0;
  localparam logic [AcgOptionWidth-1:0]    AcgIdleCommandOption = '0;
  localparam logic [AcgNumOfDataWidth-1:0] AcgIdleNumOfData     = '0;
  localparam logic                         AcgIdleCASelect      = 1'b1;
  localparam logic [AcgCADataWidth-1:0]    AcgIdleCAData        = '0;

  // One-hot step requests inside the ACG Command byte
  localparam int AcgCmdBitCAOut      = 0;
  localparam int AcgCmdBitDataIn     = 1;
  localparam int AcgCmdBitDataOut    = 2;
  localparam int AcgCmdBitTimer      = 3;
  localparam int AcgCmdBitReadStatus = 4;
  localparam int AcgCmdBitPinCtrl    = 5;
  localparam int AcgCmdBitReserved6  = 6;
  localparam int AcgCmdBitReserved7  = 7;

  typedef enum logic [1:0] {
    StateIdle    = 2'd0,
    StateBusy    = 2'd1,
    StateRelease = 2'd2
  } dispatchState_t;

endpackage

// File: rtl/nfc_command_dispatch_if.sv
// Bundle between the command dispatcher, the per-command modules and the ACG layer.
// master is the dispatcher side, slave is the environment side.
interface nfc_command_dispatch_if
  import nfc_pkg::*;
#(
  parameter int NumberOfWays = 4,
  parameter int NumOfModules = 8
);
  logic                                      iCMDValid;
  logic                                      oCMDReady;
  logic [NumOfModules-1:0]                   iMod_Start;
  logic [NumOfModules-1:0]                   iMod_LastStep;
  logic [NumOfModules-1:0]                   iMod_CMDReady;
  logic [AcgCommandWidth*NumOfModules-1:0]   iMod_ACG_Command;
  logic [AcgOptionWidth*NumOfModules-1:0]    iMod_ACG_CommandOption;
  logic [NumberOfWays*NumOfModules-1:0]      iMod_ACG_TargetWay;
  logic [AcgNumOfDataWidth*NumOfModules-1:0] iMod_ACG_NumOfData;
  logic [NumOfModules-1:0]                   iMod_ACG_CASelect;
  logic [AcgCADataWidth*NumOfModules-1:0]    iMod_ACG_CAData;
  logic [7:0]                                iACG_LastStep;
  logic [8*NumOfModules-1:0]                 oMod_ACG_LastStep;
  logic [AcgCommandWidth-1:0]                oACG_Command;
  logic [AcgOptionWidth-1:0]                 oACG_CommandOption;
  logic [NumberOfWays-1:0]                   oACG_TargetWay;
  logic [AcgNumOfDataWidth-1:0]              oACG_NumOfData;
  logic                                      oACG_CASelect;
  logic [AcgCADataWidth-1:0]                 oACG_CAData;
  logic [NumOfModules-1:0]                   oOwner;
  logic                                      oMultiHit;
  logic                                      oUnknownCmd;
  logic                                      oTimeout;
  logic                                      iClearError;

  modport master (
    input  iCMDValid, iMod_Start, iMod_LastStep, iMod_CMDReady, iMod_ACG_Command,
           iMod_ACG_CommandOption, iMod_ACG_TargetWay, iMod_ACG_NumOfData,
           iMod_ACG_CASelect, iMod_ACG_CAData, iACG_LastStep, iClearError,
    output oCMDReady, oMod_ACG_LastStep, oACG_Command, oACG_CommandOption,
           oACG_TargetWay, oACG_NumOfData, oACG_CASelect, oACG_CAData,
           oOwner, oMultiHit, oUnknownCmd, oTimeout
  );

  modport slave (
    output iCMDValid, iMod_Start, iMod_LastStep, iMod_CMDReady, iMod_ACG_Command,
           iMod_ACG_CommandOption, iMod_ACG_TargetWay, iMod_ACG_NumOfData,
           iMod_ACG_CASelect, iMod_ACG_CAData, iACG_LastStep, iClearError,
    input  oCMDReady, oMod_ACG_LastStep, oACG_Command, oACG_CommandOption,
           oACG_TargetWay, oACG_NumOfData, oACG_CASelect, oACG_CAData,
           oOwner, oMultiHit, oUnknownCmd, oTimeout
  );
endinterface

// File: rtl/nfc_prio_onehot.sv
// Lowest-index one-hot select over a request vector, flagging when more than
// one request is present.
module nfc_prio_onehot #(
  parameter int Width = 8
) (
  input  logic [Width-1:0] req_i,
  output logic [Width-1:0] grant_o,
  output logic             multi_o
);

  // Two's-complement trick isolates the lowest set bit
  assign grant_o = req_i & (~req_i + Width'(1));
  assign multi_o = |(req_i & ~grant_o);

endmodule

// File: rtl/nfc_command_dispatch.sv
// Shares the single ACG bus among the command modules: admits one upstream
// command, grants the bus to the module whose start fired, holds it until that module's last step.
module nfc_command_dispatch
  import nfc_pkg::*;
#(
  parameter int          NumberOfWays   = 4,
  parameter int          NumOfModules   = 8,
  parameter logic [23:0] WatchdogCycles = 24'd1_000_000
) (
  input logic                    iSystemClock,
  input logic                    iReset,
  nfc_command_dispatch_if.master bus
);

  dispatchState_t          state_q, state_d;
  logic [NumOfModules-1:0] owner_q, owner_d;
  logic [NumOfModules-1:0] startSel;
  logic                    multiDet;
  logic                    accept;
  logic                    ownerDone;
  logic                    multiHit_q, multiHit_d;
  logic                    unknown_q, unknown_d;
  logic                    timeout_q, timeout_d;
  logic [23:0]             wdog_q, wdog_d;

  nfc_prio_onehot #(.Width(NumOfModules)) uPrio (
    .req_i   (bus.iMod_Start),
    .grant_o (startSel),
    .multi_o (multiDet)
  );

  assign accept    = (state_q == StateIdle) && bus.iCMDValid && (&bus.iMod_CMDReady);
  assign ownerDone = |(owner_q & bus.iMod_LastStep);

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) state_q <= StateIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StateIdle:    if (accept && (|bus.iMod_Start)) state_d = StateBusy;
      StateBusy:    if (ownerDone) state_d = StateRelease;
      StateRelease: state_d = StateIdle;
      default:      state_d = StateIdle;
    endcase
  end

  // Owner mux is AND-OR over the one-hot grant; idle values outside BUSY
  always_comb begin
    bus.oCMDReady          = (state_q == StateIdle) && (&bus.iMod_CMDReady);
    bus.oACG_Command       = '0;
    bus.oACG_CommandOption = '0;
    bus.oACG_TargetWay     = '0;
    bus.oACG_NumOfData     = '0;
    bus.oACG_CASelect      = 1'b0;
    bus.oACG_CAData        = '0;
    bus.oMod_ACG_LastStep  = '0;
    for (int k = 0; k < NumOfModules; k++) begin
      if (owner_q[k]) begin
        bus.oACG_Command       |= bus.iMod_ACG_Command[AcgCommandWidth*k +: AcgCommandWidth];
        bus.oACG_CommandOption |= bus.iMod_ACG_CommandOption[AcgOptionWidth*k +: AcgOptionWidth];
        bus.oACG_TargetWay     |= bus.iMod_ACG_TargetWay[NumberOfWays*k +: NumberOfWays];
        bus.oACG_NumOfData     |= bus.iMod_ACG_NumOfData[AcgNumOfDataWidth*k +: AcgNumOfDataWidth];
        bus.oACG_CASelect      |= bus.iMod_ACG_CASelect[k];
        bus.oACG_CAData        |= bus.iMod_ACG_CAData[AcgCADataWidth*k +: AcgCADataWidth];
        if (state_q == StateBusy) bus.oMod_ACG_LastStep[8*k +: 8] = bus.iACG_LastStep;
      end
    end
    if (state_q != StateBusy) begin
      bus.oACG_Command       = AcgIdleCommand;
      bus.oACG_CommandOption = AcgIdleCommandOption;
      bus.oACG_TargetWay     = '0;
      bus.oACG_NumOfData     = AcgIdleNumOfData;
      bus.oACG_CASelect      = AcgIdleCASelect;
      bus.oACG_CAData        = AcgIdleCAData;
    end
  end

  always_comb begin
    owner_d    = owner_q;
    multiHit_d = 1'b0;
    unknown_d  = 1'b0;
    wdog_d     = wdog_q;
    timeout_d  = timeout_q;
    if (bus.iClearError) timeout_d = 1'b0;
    if ((state_q == StateBusy) && (wdog_q == WatchdogCycles - 24'd1)) timeout_d = 1'b1;
    case (state_q)
      StateIdle: begin
        if (accept) begin
          if (|bus.iMod_Start) begin
            owner_d    = startSel;
            multiHit_d = multiDet;
            wdog_d     = '0;
          end else begin
            unknown_d  = 1'b1;
          end
        end
      end
      StateBusy: begin
        wdog_d = (wdog_q == 24'hFF_FFFF) ? wdog_q : wdog_q + 24'd1;
        if (ownerDone) owner_d = '0;
      end
      default: owner_d = '0;
    endcase
  end

  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      owner_q    <= '0;
      multiHit_q <= 1'b0;
      unknown_q  <= 1'b0;
      timeout_q  <= 1'b0;
      wdog_q     <= '0;
    end else begin
      owner_q    <= owner_d;
      multiHit_q <= multiHit_d;
      unknown_q  <= unknown_d;
      timeout_q  <= timeout_d;
      wdog_q     <= wdog_d;
    end
  end

  assign bus.oOwner      = owner_q;
  assign bus.oMultiHit   = multiHit_q;
  assign bus.oUnknownCmd = unknown_q;
  assign bus.oTimeout    = timeout_q;

endmodule

// File: tb/tb_nfc_command_dispatch.sv
// Directed and randomized bench for nfc_command_dispatch, checked against a
// transaction-level model of the grant lifecycle.
module tb_nfc_command_dispatch;

  localparam int Ways    = 4;
  localparam int Mods    = 8;
  localparam int WdCycle = 16;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  // Model: who owns the bus, whether we sit in the release gap, flag states
  int   mOwner;
  bit   mReleasing;
  int   mBusyCycles;
  bit   mTimeout;
  bit   mMulti;
  bit   mUnknown;

  nfc_command_dispatch_if #(.NumberOfWays(Ways), .NumOfModules(Mods)) bus ();

  nfc_command_dispatch #(
    .NumberOfWays   (Ways),
    .NumOfModules   (Mods),
    .WatchdogCycles (24'(WdCycle))
  ) dut (
    .iSystemClock (clk),
    .iReset       (rst),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mOwner      = -1;
    mReleasing  = 1'b0;
    mBusyCycles = 0;
    mTimeout    = 1'b0;
    mMulti      = 1'b0;
    mUnknown    = 1'b0;
  endtask

  // Advance the model by one clock using the inputs held across that edge
  task automatic modelUpdate();
    bit setCond;
    if (rst) begin
      modelReset();
      return;
    end
    setCond  = (mOwner >= 0) && (mBusyCycles == WdCycle - 1);
    mMulti   = 1'b0;
    mUnknown = 1'b0;
    if (setCond) mTimeout = 1'b1;
    else if (bus.iClearError) mTimeout = 1'b0;
    if (mReleasing) begin
      mReleasing = 1'b0;
    end else if (mOwner >= 0) begin
      mBusyCycles++;
      if (bus.iMod_LastStep[mOwner]) begin
        mOwner     = -1;
        mReleasing = 1'b1;
      end
    end else if (bus.iCMDValid && (bus.iMod_CMDReady == '1)) begin
      if (bus.iMod_Start != 0) begin
        for (int k = Mods - 1; k >= 0; k--) if (bus.iMod_Start[k]) mOwner = k;
        mMulti      = $countones(bus.iMod_Start) > 1;
        mBusyCycles = 0;
      end else begin
        mUnknown = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    logic [7:0]  eCmd;
    logic [2:0]  eOpt;
    logic [3:0]  eWay;
    logic [15:0] eNum;
    logic        eCas;
    logic [39:0] eCa;
    logic [63:0] eLast;
    logic [7:0]  eOwner;
    eCmd = 8'h00; eOpt = 3'h0; eWay = 4'h0; eNum = 16'h0; eCas = 1'b1; eCa = 40'h0;
    eLast = 64'h0; eOwner = 8'h00;
    if (mOwner >= 0) begin
      eCmd   = bus.iMod_ACG_Command[8*mOwner +: 8];
      eOpt   = bus.iMod_ACG_CommandOption[3*mOwner +: 3];
      eWay   = bus.iMod_ACG_TargetWay[Ways*mOwner +: Ways];
      eNum   = bus.iMod_ACG_NumOfData[16*mOwner +: 16];
      eCas   = bus.iMod_ACG_CASelect[mOwner];
      eCa    = bus.iMod_ACG_CAData[40*mOwner +: 40];
      eLast  = 64'(bus.iACG_LastStep) << (8 * mOwner);
      eOwner = 8'(1 << mOwner);
    end
    checkVal("cmdReady", bus.oCMDReady, (mOwner < 0) && !mReleasing && (bus.iMod_CMDReady == '1));
    checkVal("owner", bus.oOwner, eOwner);
    checkVal("multiHit", bus.oMultiHit, mMulti);
    checkVal("unknownCmd", bus.oUnknownCmd, mUnknown);
    checkVal("timeout", bus.oTimeout, mTimeout);
    checkVal("acgCommand", bus.oACG_Command, eCmd);
    checkVal("acgOption", bus.oACG_CommandOption, eOpt);
    checkVal("acgTargetWay", bus.oACG_TargetWay, eWay);
    checkVal("acgNumOfData", bus.oACG_NumOfData, eNum);
    checkVal("acgCASelect", bus.oACG_CASelect, eCas);
    checkVal("acgCAData", bus.oACG_CAData, eCa);
    checkVal("modLastStep", bus.oMod_ACG_LastStep, eLast);
  endtask

  task automatic randomizeFields();
    for (int k = 0; k < Mods; k++) begin
      bus.iMod_ACG_Command[8*k +: 8]        = 8'($urandom);
      bus.iMod_ACG_CommandOption[3*k +: 3]  = 3'($urandom);
      bus.iMod_ACG_TargetWay[Ways*k +: Ways] = Ways'($urandom);
      bus.iMod_ACG_NumOfData[16*k +: 16]    = 16'($urandom);
      bus.iMod_ACG_CASelect[k]              = 1'($urandom);
      bus.iMod_ACG_CAData[40*k +: 40]       = {8'($urandom), 32'($urandom)};
    end
  endtask

  // Drive one cycle's inputs, then check outputs against the model
  task automatic applyStimulus(input logic valid, input logic [7:0] start, input logic [7:0] modLast,
                               input logic [7:0] acgLast, input logic clear);
    bus.iCMDValid     = valid;
    bus.iMod_Start    = start;
    bus.iMod_LastStep = modLast;
    bus.iACG_LastStep = acgLast;
    bus.iClearError   = clear;
    #1;
    checkOutput();
  endtask

  task automatic tick();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.iMod_CMDReady = '1;
    randomizeFields();
    modelReset();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkVal("reset_caselect", bus.oACG_CASelect, 1'b1);
    rst = 1'b0;

    // Module 2 grant, completion, release gap
    bus.iMod_ACG_CAData[80 +: 40] = 40'hEE_0000_0000;
    applyStimulus(1'b1, 8'h04, 8'h00, 8'h00, 1'b0); tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkVal("mod2_owner", bus.oOwner, 8'b0000_0100);
    checkVal("mod2_cadata", bus.oACG_CAData, 40'hEE_0000_0000);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h04, 8'h00, 1'b0); tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkVal("release_ready", bus.oCMDReady, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkVal("after_release_ready", bus.oCMDReady, 1'b1);

    // Simultaneous starts 3 and 5
    applyStimulus(1'b1, 8'h28, 8'h00, 8'h00, 1'b0); tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkVal("multi_owner", bus.oOwner, 8'h08);
    checkVal("multi_pulse", bus.oMultiHit, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h08, 8'h00, 1'b0);
    checkVal("multi_pulse_end", bus.oMultiHit, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0); tick();

    // Valid with no start
    applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, 1'b0); tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkVal("unknown_pulse", bus.oUnknownCmd, 1'b1);
    checkVal("unknown_ready", bus.oCMDReady, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0); tick();

    // Non-owner LastStep while module 4 owns
    applyStimulus(1'b1, 8'h10, 8'h00, 8'h00, 1'b0); tick();
    applyStimulus(1'b0, 8'h00, 8'h02, 8'h08, 1'b0);
    checkVal("route_slice4", bus.oMod_ACG_LastStep, 64'h0000_0008_0000_0000);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkVal("nonowner_ignored", bus.oOwner, 8'h10);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h10, 8'h00, 1'b0); tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0); tick();

    // Watchdog: owner never finishes
    applyStimulus(1'b1, 8'h01, 8'h00, 8'h00, 1'b0); tick();
    for (int i = 0; i < WdCycle; i++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0); tick();
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkVal("wdog_set", bus.oTimeout, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1); tick();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0); tick();
    end
    checkVal("wdog_cleared", bus.oTimeout, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h01, 8'h00, 1'b0); tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0); tick();
    applyStimulus(1'b1, 8'h01, 8'h00, 8'h00, 1'b0); tick();
    for (int i = 0; i < WdCycle; i++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0); tick();
    end
    checkVal("wdog_reset_again", bus.oTimeout, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h01, 8'h00, 1'b1); tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1); tick();

    // Asynchronous reset while BUSY
    bus.iMod_ACG_Command[40 +: 8] = 8'hA5;
    applyStimulus(1'b1, 8'h20, 8'h00, 8'h00, 1'b0); tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkVal("rst_owner", bus.oOwner, 8'h00);
    checkVal("rst_command", bus.oACG_Command, 8'h00);
    checkOutput();
    rst = 1'b0;
    applyStimulus(1'b1, 8'h02, 8'h00, 8'h00, 1'b0); tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkVal("post_rst_owner", bus.oOwner, 8'h02);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) randomizeFields();
      bus.iMod_CMDReady = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                    8'($urandom),
                    1'($urandom_range(0, 15) == 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nfc_command_dispatch.md
# nfc_command_dispatch

Arbiter/sequencer that shares the single atomic-command-generator (ACG) bus among the per-command modules (reset, get/set feature, read/program page, erase, ...). It admits one upstream command at a time, identifies the module that decoded it via that module's start strobe, and grants the ACG bus to that module. The grant is held until the module reports its last step. It sits between the command modules and the ACG layer inside the NAND flash controller.

## Interface
- NumberOfWays, 4, ways per channel; width of TargetWay.
- NumOfModules, 8, command modules attached; index 0 has highest priority.
- WatchdogCycles, 24'd1_000_000, BUSY cycles before oTimeout sets.

Ports:
- iSystemClock  in  1  clock
- iReset  in  1  reset; iReset, asynchronous, active-high; clock iSystemClock
- iCMDValid  in  1  upstream command valid; also broadcast to modules externally
- oCMDReady  out  1  upstream ready
- iMod_Start  in  NumOfModules  per-module decoded start (combinational in modules)
- iMod_LastStep  in  NumOfModules  per-module completion pulse
- iMod_CMDReady  in  NumOfModules  per-module ready
- iMod_ACG_Command  in  8*NumOfModules  packed, module k at [8k+7:8k]
- iMod_ACG_CommandOption  in  3*NumOfModules  packed
- iMod_ACG_TargetWay  in  NumberOfWays*NumOfModules  packed
- iMod_ACG_NumOfData  in  16*NumOfModules  packed
- iMod_ACG_CASelect  in  NumOfModules
- iMod_ACG_CAData  in  40*NumOfModules  packed
- iACG_LastStep  in  8  from ACG
- oMod_ACG_LastStep  out  8*NumOfModules  iACG_LastStep to owner only, zero elsewhere
- oACG_Command / oACG_CommandOption / oACG_TargetWay / oACG_NumOfData / oACG_CASelect / oACG_CAData  out  8/3/NumberOfWays/16/1/40  muxed ACG bus
- oOwner  out  NumOfModules  one-hot current grant, 0 when idle
- oMultiHit  out  1  one-cycle pulse: more than one start at acceptance
- oUnknownCmd  out  1  one-cycle pulse: accepted command matched no module
- oTimeout  out  1  sticky watchdog flag
- iClearError  in  1  synchronous clear of oTimeout

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - oCMDReady = &iMod_CMDReady (combinational with state).
  - Acceptance = iCMDValid & oCMDReady.
  - On acceptance with iMod_Start != 0: owner <= lowest set index (one-hot), go to BUSY. oMultiHit pulses next cycle if popcount(iMod_Start) > 1.
  - On acceptance with iMod_Start == 0: command is consumed. oUnknownCmd pulses next cycle; state stays IDLE.
- BUSY:
  - oCMDReady = 0.
  - ACG outputs = owner's fields.
  - oMod_ACG_LastStep routes iACG_LastStep to the owner slice only.
  - Owner's iMod_LastStep goes to RELEASE. LastStep from any non-owner module is ignored.
- RELEASE:
  - Lasts exactly one cycle.
  - ACG outputs take idle values; oCMDReady = 0; owner cleared.
  - Next state is IDLE.
- Idle ACG values: Command 0, CommandOption 0, TargetWay 0, NumOfData 0, CASelect 1, CAData 0.
- Watchdog:
  - 24-bit counter, cleared on entry to BUSY, increments each BUSY cycle, saturates.
  - At count == WatchdogCycles-1, oTimeout sets. Grant is not revoked.
  - iClearError clears oTimeout. If iClearError and a set condition occur in the same cycle, set wins.

## Timing
- Reset values: state IDLE, owner 0, oCMDReady = &iMod_CMDReady, ACG outputs at idle values, oMultiHit/oUnknownCmd/oTimeout 0, watchdog 0.
- ACG mux is combinational from the registered owner. ACG outputs follow the owner from the first BUSY cycle, one cycle after acceptance. This matches the modules' registered ACG outputs, which first change in that same cycle.
- Minimum occupancy: acceptance cycle, then BUSY ≥1 cycle, then RELEASE 1 cycle. Next acceptance is possible no earlier than 3 cycles after the previous one.
- LastStep arriving in the first BUSY cycle is honoured.
- Reset asserted mid-BUSY: outputs return to reset values immediately (asynchronous); the grant is lost.

## Structure
- Shared package nfc_pkg holds:
  - ACG field widths (8/3/16/40).
  - ACG idle-value constants.
  - ACG Command bit indices.
- Sub-module nfc_prio_onehot: lowest-index one-hot select plus multi-hit detect, parameterised on width.
- All else lives in a single module.

## Test plan
- Module 2 start with valid: oOwner = 8'b0000_0100 next cycle. oACG_CAData = module 2's 40'hEE_0000_0000. LastStep2 → one RELEASE cycle, then oCMDReady = 1.
- Starts 3 and 5 together: grant = module 3; oMultiHit pulses for exactly 1 cycle.
- Valid with no start: oUnknownCmd pulses once; state stays IDLE; oCMDReady stays 1.
- Non-owner module 1 pulses LastStep while module 4 owns: no release. iACG_LastStep = 8'h08 appears only on slice 4.
- WatchdogCycles = 16, owner never finishes: oTimeout = 1 at BUSY cycle 16 and stays set. iClearError clears it; it sets again at the next saturation only after re-entry to BUSY.
- iReset asserted in BUSY: oOwner = 0 and oACG_Command = 0 in the same cycle; normal grant works after release.
